// File: rtl/mem_arbiter2.sv
// mem_arbiter2: merges the instruction-fetch and data ports onto one registered valid/ready
// memory bus. One transaction is outstanding at a time; contested cycles are granted round-robin.
module mem_arbiter2 #(
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,

    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;  // 0 = instruction won last, 1 = data won last
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;
    logic        grant_i, grant_d;

    // A lone requester always wins; when both ask, the port not granted last time wins.
    assign grant_i = i_valid && (!d_valid || last_grant_q);
    assign grant_d = d_valid && (!i_valid || !last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_valid_d    = m_valid_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        unique case (state_q)
            StIdle: begin
                if (grant_i) begin
                    state_d      = StBusyI;
                    last_grant_d = 1'b0;
                    m_valid_d    = 1'b1;
                    m_addr_d     = i_addr;
                    m_wdata_d    = 32'h0;
                    m_wstrb_d    = 4'b0000;
                end else if (grant_d) begin
                    state_d      = StBusyD;
                    last_grant_d = 1'b1;
                    m_valid_d    = 1'b1;
                    m_addr_d     = d_addr;
                    m_wdata_d    = d_wdata;
                    m_wstrb_d    = d_wstrb;
                end
            end
            StBusyI, StBusyD: begin
                if (m_ready) begin
                    state_d   = StIdle;
                    m_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = StIdle;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            last_grant_q <= ~PRIO_RESET;
            m_valid_q    <= 1'b0;
            m_addr_q     <= 32'h0;
            m_wdata_q    <= 32'h0;
            m_wstrb_q    <= 4'b0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;

    assign i_ready = m_ready && (state_q == StBusyI);
    assign d_ready = m_ready && (state_q == StBusyD);
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2 with a byte-addressed memory model that can stall its response.
module tb_mem_arbiter2;

    logic        clk, resetn;
    logic        i_valid, i_ready, d_valid, d_ready;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb, m_wstrb;
    logic        m_valid, m_ready, mem_ready, spur_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic [7:0] mem [0:255];
    int stall = 0;
    int wait_cnt;
    int vectors = 0;
    int miscompares = 0;

    assign m_ready = mem_ready | spur_ready;

    mem_arbiter2 #(.PRIO_RESET(1'b0)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wstrb (d_wstrb),
        .d_rdata (d_rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory answers `stall` cycles after first seeing m_valid, byte lanes at addr+k.
    always @(posedge clk) begin
        if (resetn && m_valid && !mem_ready) begin
            if (wait_cnt < stall) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                mem_ready <= 1'b1;
                wait_cnt  <= 0;
                m_rdata   <= {mem[m_addr[7:0] + 8'd3], mem[m_addr[7:0] + 8'd2],
                              mem[m_addr[7:0] + 8'd1], mem[m_addr[7:0]]};
                for (int k = 0; k < 4; k++)
                    if (m_wstrb[k]) mem[m_addr[7:0] + 8'(k)] <= m_wdata[8*k +: 8];
            end
        end else begin
            mem_ready <= 1'b0;
            wait_cnt  <= 0;
        end
    end

    task automatic do_data(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rdata, output int lat);
        d_valid = 1'b1; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
        lat = -1; rdata = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (d_ready) begin
                lat = c; rdata = d_rdata;
                break;
            end
        end
        d_valid = 1'b0; d_wstrb = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        @(negedge clk);
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        vectors++; if (m_addr !== 32'h0) begin miscompares++; $display("FAIL reset_m_addr: got %h want 0", m_addr); end
        vectors++; if (m_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_m_wdata: got %h want 0", m_wdata); end
        vectors++; if (m_wstrb !== 4'h0) begin miscompares++; $display("FAIL reset_m_wstrb: got %b want 0000", m_wstrb); end
        vectors++; if ({i_ready, d_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_readies: got %b want 00", {i_ready, d_ready}); end
        resetn = 1'b1;
        @(negedge clk);
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_idle_after: got %b want 0", m_valid); end
    endtask

    task automatic test_single_fetch;
        i_valid = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_m_valid_c1: got %b want 1", m_valid); end
        vectors++; if (m_addr !== 32'h10) begin miscompares++; $display("FAIL fetch_m_addr: got %h want 00000010", m_addr); end
        vectors++; if ({m_wstrb, m_wdata} !== 36'h0) begin miscompares++; $display("FAIL fetch_m_wr: got %b/%h want 0000/0", m_wstrb, m_wdata); end
        vectors++; if (i_ready !== 1'b0) begin miscompares++; $display("FAIL fetch_ready_early: got %b want 0", i_ready); end
        @(negedge clk);
        vectors++; if (i_ready !== 1'b1) begin miscompares++; $display("FAIL fetch_i_ready_c2: got %b want 1", i_ready); end
        vectors++; if (i_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fetch_rdata: got %h want deadbeef", i_rdata); end
        vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL fetch_d_ready: got %b want 0", d_ready); end
        i_valid = 1'b0;
        @(negedge clk);
        vectors++; if ({m_valid, i_ready} !== 2'b00) begin miscompares++; $display("FAIL fetch_c3_idle: got %b want 00", {m_valid, i_ready}); end
    endtask

    task automatic test_data_rw;
        logic [31:0] r;
        int lat;
        do_data(32'h20, 32'h12345678, 4'b1111, r, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rw_write_latency: got %0d want 2", lat); end
        do_data(32'h20, 32'h0, 4'b0000, r, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rw_read_latency: got %0d want 2", lat); end
        vectors++; if (r !== 32'h12345678) begin miscompares++; $display("FAIL rw_readback: got %h want 12345678", r); end
    endtask

    task automatic test_byte_half;
        logic [31:0] r;
        int lat;
        do_data(32'h30, 32'h000000AA, 4'b0001, r, lat);
        do_data(32'h32, 32'h0000BBCC, 4'b0011, r, lat);
        do_data(32'h30, 32'h0, 4'b0000, r, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL bh_latency: got %0d want 2", lat); end
        vectors++; if (r !== 32'hBBCC5AAA) begin miscompares++; $display("FAIL bh_readback: got %h want bbcc5aaa", r); end
    endtask

    task automatic test_contention;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        i_valid = 1'b1; i_addr = 32'h10;
        d_valid = 1'b1; d_addr = 32'h20; d_wdata = 32'h55555555; d_wstrb = 4'b0000;
        @(negedge clk);  // c1
        vectors++; if (m_addr !== 32'h10) begin miscompares++; $display("FAIL cont_first_i: got %h want 00000010", m_addr); end
        vectors++; if (m_wdata !== 32'h0) begin miscompares++; $display("FAIL cont_i_wdata: got %h want 0", m_wdata); end
        @(negedge clk);  // c2
        vectors++; if ({i_ready, d_ready} !== 2'b10) begin miscompares++; $display("FAIL cont_ready_c2: got %b want 10", {i_ready, d_ready}); end
        i_addr = 32'h14;  // new fetch in the completion cycle: not sampled until IDLE
        @(negedge clk);  // c3
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL cont_gap_c3: got %b want 0", m_valid); end
        @(negedge clk);  // c4
        vectors++; if ({m_valid, m_addr} !== {1'b1, 32'h20}) begin miscompares++; $display("FAIL cont_second_d: got %b/%h want 1/00000020", m_valid, m_addr); end
        @(negedge clk);  // c5
        vectors++; if ({i_ready, d_ready} !== 2'b01) begin miscompares++; $display("FAIL cont_ready_c5: got %b want 01", {i_ready, d_ready}); end
        vectors++; if (d_rdata !== 32'h12345678) begin miscompares++; $display("FAIL cont_d_rdata: got %h want 12345678", d_rdata); end
        d_valid = 1'b0;
        @(negedge clk);  // c6
        @(negedge clk);  // c7
        vectors++; if (m_addr !== 32'h14) begin miscompares++; $display("FAIL cont_third_i: got %h want 00000014", m_addr); end
        @(negedge clk);  // c8
        i_valid = 1'b0;
        @(negedge clk);  // c9: contested again after an instruction grant
        i_valid = 1'b1; i_addr = 32'h10;
        d_valid = 1'b1; d_addr = 32'h30;
        @(negedge clk);  // c10
        vectors++; if (m_addr !== 32'h30) begin miscompares++; $display("FAIL cont_alt_d: got %h want 00000030", m_addr); end
        @(negedge clk);  // c11
        vectors++; if ({d_ready, d_rdata} !== {1'b1, 32'hBBCC5AAA}) begin miscompares++; $display("FAIL cont_alt_d_done: got %b/%h want 1/bbcc5aaa", d_ready, d_rdata); end
        d_valid = 1'b0;
        @(negedge clk);  // c12
        @(negedge clk);  // c13
        vectors++; if (m_addr !== 32'h10) begin miscompares++; $display("FAIL cont_alt_i: got %h want 00000010", m_addr); end
        @(negedge clk);  // c14
        vectors++; if (i_ready !== 1'b1) begin miscompares++; $display("FAIL cont_alt_i_done: got %b want 1", i_ready); end
        i_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall;
        int pulses, spurious, ready_cyc;
        pulses = 0; spurious = 0; ready_cyc = -1;
        stall = 3;
        d_valid = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; d_wstrb = 4'b1111;
        @(negedge clk);  // c1
        vectors++; if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 32'h40, 32'hCAFEF00D, 4'hF}) begin
            miscompares++; $display("FAIL stall_issue: got %b/%h/%h/%b want 1/00000040/cafef00d/1111", m_valid, m_addr, m_wdata, m_wstrb); end
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (i_ready) spurious++;
            if (d_ready) begin
                pulses++; ready_cyc = c;
                d_valid = 1'b0; d_wstrb = 4'b0000;
            end
            if (c <= 5) begin
                vectors++; if ({m_addr, m_wdata, m_wstrb} !== {32'h40, 32'hCAFEF00D, 4'hF}) begin
                    miscompares++; $display("FAIL stall_hold_c%0d: got %h/%h/%b want 00000040/cafef00d/1111", c, m_addr, m_wdata, m_wstrb); end
            end
        end
        vectors++; if (pulses !== 1 || spurious !== 0) begin miscompares++; $display("FAIL stall_pulses: got d=%0d i=%0d want d=1 i=0", pulses, spurious); end
        vectors++; if (ready_cyc !== 5) begin miscompares++; $display("FAIL stall_ready_cycle: got %0d want 5", ready_cyc); end
        stall = 0;
    endtask

    task automatic test_idle_ready;
        logic [31:0] r;
        int lat;
        spur_ready = 1'b1;
        #1;
        vectors++; if ({i_ready, d_ready} !== 2'b00) begin miscompares++; $display("FAIL idle_ready_pulse: got %b want 00", {i_ready, d_ready}); end
        @(negedge clk);
        spur_ready = 1'b0;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL idle_ready_m_valid: got %b want 0", m_valid); end
        do_data(32'h40, 32'h0, 4'b0000, r, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL idle_ready_next_lat: got %0d want 2", lat); end
        vectors++; if (r !== 32'hCAFEF00D) begin miscompares++; $display("FAIL idle_ready_next_data: got %h want cafef00d", r); end
    endtask

    task automatic test_reset_mid;
        stall = 5;
        d_valid = 1'b1; d_addr = 32'h50; d_wdata = 32'h11223344; d_wstrb = 4'b1111;
        @(negedge clk);
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_busy: got %b want 1", m_valid); end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        vectors++; if ({m_valid, m_addr, m_wdata, m_wstrb} !== 69'h0) begin
            miscompares++; $display("FAIL rmid_async_clear: got %b/%h/%h/%b want all zero", m_valid, m_addr, m_wdata, m_wstrb); end
        vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_d_ready: got %b want 0", d_ready); end
        d_valid = 1'b0; d_wstrb = 4'b0000;
        @(negedge clk);
        resetn = 1'b1; stall = 0;
        i_valid = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        vectors++; if ({m_valid, m_addr} !== {1'b1, 32'h10}) begin miscompares++; $display("FAIL rmid_fresh_issue: got %b/%h want 1/00000010", m_valid, m_addr); end
        @(negedge clk);
        vectors++; if ({i_ready, d_ready, i_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL rmid_fresh_done: got %b%b/%h want 10/deadbeef", i_ready, d_ready, i_rdata); end
        i_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want summary before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        i_valid = 1'b0; i_addr = 32'h0;
        d_valid = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'b0000;
        spur_ready = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h10] = 8'hEF; mem[8'h11] = 8'hBE; mem[8'h12] = 8'hAD; mem[8'h13] = 8'hDE;
        mem[8'h31] = 8'h5A;
        test_reset();
        test_single_fetch();
        test_data_rw();
        test_byte_half();
        test_contention();
        test_stall();
        test_idle_ready();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
